// File: rtl/laser_bank.sv
// Multi-slot laser manager: spawns lasers into the lowest free slot, steps them toward
// decreasing x on each frame tick and retires them at the playfield edge or on a hit.
module laser_bank #(
  parameter int unsigned NUM_LASERS = 4,
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 7,
  parameter int unsigned STEP       = 2,
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned COOLDOWN   = 8,
  parameter int unsigned SLOT_W     = (NUM_LASERS > 1) ? $clog2(NUM_LASERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      fire,
  input  logic [X_W-1:0]            origin_x,
  input  logic [Y_W-1:0]            origin_y,
  input  logic                      tick,
  input  logic [NUM_LASERS-1:0]     hit_clear,
  output logic [NUM_LASERS*X_W-1:0] x_pos,
  output logic [NUM_LASERS*Y_W-1:0] y_pos,
  output logic [NUM_LASERS-1:0]     active,
  output logic                      fired,
  output logic [SLOT_W-1:0]         fired_slot,
  output logic                      full
);

  localparam int unsigned CdW     = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  // Unwrapped edge threshold: x below this cannot take another full step.
  localparam int unsigned EdgeLim = X_MIN + STEP;

  logic [NUM_LASERS-1:0][X_W-1:0] x_q, x_d;
  logic [NUM_LASERS-1:0][Y_W-1:0] y_q, y_d;
  logic [NUM_LASERS-1:0]          active_q, active_d;
  logic [CdW-1:0]                 cd_q, cd_d;
  logic                           fired_q, fired_d;
  logic [SLOT_W-1:0]              fired_slot_q, fired_slot_d;

  logic              free_found;
  logic [SLOT_W-1:0] free_idx;
  logic              accept;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_LASERS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  assign accept = fire && (cd_q == '0) && free_found;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    active_d     = active_q;
    cd_d         = cd_q;
    fired_d      = accept;
    fired_slot_d = fired_slot_q;

    for (int i = 0; i < NUM_LASERS; i++) begin
      if (accept && (free_idx == SLOT_W'(i))) begin
        x_d[i]      = origin_x;
        y_d[i]      = origin_y;
        active_d[i] = 1'b1;
      end else if (hit_clear[i] && active_q[i]) begin
        active_d[i] = 1'b0;
      end else if (tick && active_q[i]) begin
        if (32'(x_q[i]) < EdgeLim) begin
          active_d[i] = 1'b0;
        end else begin
          x_d[i] = x_q[i] - X_W'(STEP);
        end
      end
    end

    if (accept) begin
      cd_d         = CdW'(COOLDOWN);
      fired_slot_d = free_idx;
    end else if (tick && (cd_q != '0)) begin
      cd_d = cd_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      active_q     <= '0;
      cd_q         <= '0;
      fired_q      <= 1'b0;
      fired_slot_q <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      active_q     <= active_d;
      cd_q         <= cd_d;
      fired_q      <= fired_d;
      fired_slot_q <= fired_slot_d;
    end
  end

  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign active     = active_q;
  assign fired      = fired_q;
  assign fired_slot = fired_slot_q;
  assign full       = &active_q;

endmodule

// File: doc/laser_bank.md
# laser_bank

Parametrised multi-shot laser manager for the space-invaders datapath. Holds up to NUM_LASERS independent lasers. Each laser spawns at a caller-supplied origin and moves toward decreasing x by STEP pixels per frame tick. A laser is retired when it reaches the playfield edge or when the collision logic clears it. Position and active vectors feed the renderer and the hit-detection block directly.

## Interface
- NUM_LASERS, 4, number of laser slots (>= 1)
- X_W, 8, x-coordinate width
- Y_W, 7, y-coordinate width
- STEP, 2, pixels subtracted from x per tick (>= 1, < 2^X_W)
- X_MIN, 0, smallest legal x; a laser leaving [X_MIN, 2^X_W-1] is retired
- COOLDOWN, 8, ticks after an accepted fire before the next fire is accepted (0 = no cooldown)
- SLOT_W, max(1, clog2(NUM_LASERS)), derived slot-index width
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- fire  in  1  fire request, level-sensitive (space bar)
- origin_x  in  X_W  spawn x, sampled on accepted fire
- origin_y  in  Y_W  spawn y, sampled on accepted fire; held constant for the laser's life
- tick  in  1  one-cycle frame strobe; moves lasers and decrements cooldown
- hit_clear  in  NUM_LASERS  per-slot retire request from collision logic
- x_pos  out  NUM_LASERS*X_W  packed x, slot i at [i*X_W +: X_W]
- y_pos  out  NUM_LASERS*Y_W  packed y, slot i at [i*Y_W +: Y_W]
- active  out  NUM_LASERS  slot i in flight
- fired  out  1  one-cycle pulse: a fire was accepted last cycle
- fired_slot  out  SLOT_W  slot loaded by the last accepted fire
- full  out  1  all slots active (combinational AND of registered active)

## Operation
- State per slot: x (X_W), y (Y_W), active. Global: cooldown counter, fired, fired_slot.
- Reset (reset_n=0, asynchronous): all x, y, active = 0; cooldown = 0; fired = 0; fired_slot = 0; full = 0 (0 only while NUM_LASERS >= 1 slots are idle).
- Free slot = registered active bit is 0. Slots freed in the current cycle are not free until the next cycle.
- Fire acceptance: fire=1 AND cooldown=0 AND some free slot exists. The lowest-index free slot gets x<=origin_x, y<=origin_y, active<=1. Also fired<=1, fired_slot<=index, cooldown<=COOLDOWN.
- A fire that is not accepted is dropped without being queued. In that case fired<=0, and the cooldown counter and fired_slot are unchanged.
- Holding fire high re-fires automatically each time cooldown reaches 0 and a slot is free.
- On tick, the cooldown counter decrements if nonzero and saturates at 0. Non-tick cycles leave it unchanged.
- On tick, each active slot not loaded or cleared this cycle is updated:
  - if x < X_MIN + STEP (compare in X_W+1 bits, no wrap), active<=0 and x holds its value;
  - else x<=x-STEP.
- The y coordinate never changes after spawn.
- hit_clear[i]=1 sets active[i]<=0, and x[i], y[i] hold. It is ignored on inactive slots.
- Per-slot priority within one cycle: spawn into that slot > hit_clear > tick movement/edge retire.
- x, y of inactive slots retain their last values. Consumers must qualify positions with active.

## Timing
- All outputs except full are registered. full is derived from registered active.
- Fire accepted in cycle N: active, x_pos, y_pos, fired, fired_slot update at edge N+1. fired is high for exactly cycle N+1 unless another fire is accepted.
- A laser spawned in cycle N is not moved by a tick in cycle N. Its first move is on the next tick.
- Tick in cycle N: movements, retirements and cooldown change are visible at N+1.
- The cooldown decrement on the tick that coincides with an accepted fire is overridden by the reload to COOLDOWN.
- Minimum spacing between accepted fires: COOLDOWN ticks after the accepting cycle. With COOLDOWN=0, one accepted fire per cycle while slots are free.
- Reset asserted mid-flight clears all state immediately, without waiting for a clock. Release is synchronous to the next edge.

## Test plan
All scenarios use NUM_LASERS=4, STEP=2, X_MIN=0, COOLDOWN=3, X_W=8, Y_W=7.

- Reset: pulse reset_n low between edges -> active=0000, all x_pos/y_pos=0, fired=0, full=0, with no clock edge required.
- Single shot: fire for one cycle with origin (155,40) -> next cycle active=0001, slot0=(155,40), fired=1, fired_slot=0. After 3 ticks, slot0 x=149 and y stays 40.
- Cooldown and autofire: hold fire high with ticks every 4 cycles -> fires are accepted into slots 0,1,2,3 with exactly 3 ticks between acceptances; no fired pulse appears in between.
- Full drop: with all 4 slots active and cooldown=0, assert fire -> full=1, fired=0, no slot changes, cooldown stays 0.
- Edge retire: slot0 at x=3, tick -> x=1, active=1. Next tick -> active[0]=0, x holds 1. Next fire loads slot0.
- Simultaneous events: with slots 0,1 active and slot2 free, assert fire, tick and hit_clear=0010 in the same cycle -> slot1 is retired, slot0 moves by 2, the new laser goes to slot2 unmoved, and fired_slot=2.
